// File: rtl/rx_rate_ctrl_if.sv
// rx_rate_ctrl_if: bundle of the rate-change request side and the status and
// rate outputs of rx_rate_ctrl.
//   master : drives the request (rate_req, target_gen, numberOfDetectedLanes,
//            PhyStatus) and observes GEN, rate_out, disableDescrambler,
//            rx_flush, busy, done and err.
//   slave  : the rate controller itself.
interface rx_rate_ctrl_if;
  logic        rate_req;
  logic [2:0]  target_gen;
  logic [4:0]  numberOfDetectedLanes;
  logic [15:0] PhyStatus;
  logic [2:0]  GEN;
  logic [2:0]  rate_out;
  logic        disableDescrambler;
  logic        rx_flush;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output rate_req, target_gen, numberOfDetectedLanes, PhyStatus,
    input  GEN, rate_out, disableDescrambler, rx_flush, busy, done, err
  );

  modport slave (
    input  rate_req, target_gen, numberOfDetectedLanes, PhyStatus,
    output GEN, rate_out, disableDescrambler, rx_flush, busy, done, err
  );
endinterface

// File: rtl/rx_rate_ctrl.sv
// rx_rate_ctrl: sequences a receive-side link rate change.
//   IDLE -> DRAIN (flush RX, descrambler off) -> RATE (new rate to the PHY,
//   wait for PhyStatus on every active lane) -> SETTLE -> DONE (commit GEN).
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   rif   : rx_rate_ctrl_if.slave -- request, lane count, PhyStatus in;
//           GEN, rate_out, disableDescrambler, rx_flush, busy, done, err out
// Optional feature: define RX_RATE_CTRL_TIMEOUT_EN to bound the PhyStatus
// wait in RATE by TIMEOUT_CYCLES; on expiry the old rate is restored and err
// pulses. Without the macro RATE waits indefinitely and no timer exists.
module rx_rate_ctrl #(
  parameter int DRAIN_CYCLES   = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic          clk,
  input  logic          reset,
  rx_rate_ctrl_if.slave rif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRAIN  = 3'd1;
  localparam logic [2:0] S_RATE   = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int DW = $clog2(DRAIN_CYCLES) + 1;
  localparam int SW = $clog2(SETTLE_CYCLES) + 1;

  logic [2:0]    state;
  logic [2:0]    tgt;
  logic [2:0]    gen_q;
  logic [2:0]    rate_q;
  logic [15:0]   mask;
  logic [15:0]   sticky;
  logic [DW-1:0] drain_cnt;
  logic [SW-1:0] settle_cnt;
  logic          done_q;
  logic          err_q;
  logic          tgt_ok;
  logic          tmo_hit;

  // Unsupported lane counts fall back to a single lane.
  function automatic logic [15:0] lane_mask(input logic [4:0] n);
    case (n)
      5'd2:    return 16'h0003;
      5'd4:    return 16'h000f;
      5'd8:    return 16'h00ff;
      5'd16:   return 16'hffff;
      default: return 16'h0001;
    endcase
  endfunction

  assign tgt_ok = (rif.target_gen != 3'd0) && (rif.target_gen <= 3'd3);

`ifdef RX_RATE_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_cnt;

  // Counts RATE cycles from zero on entry; held clear in every other state.
  always_ff @(posedge clk) begin
    if (reset || state != S_RATE) tmo_cnt <= '0;
    else if (tmo_cnt != '1)       tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state == S_RATE) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      tgt        <= 3'd1;
      gen_q      <= 3'd1;
      rate_q     <= 3'd1;
      mask       <= '0;
      sticky     <= '0;
      drain_cnt  <= '0;
      settle_cnt <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rif.rate_req) begin
            if (!tgt_ok) begin
              err_q <= 1'b1;
            end else if (rif.target_gen == gen_q) begin
              done_q <= 1'b1;
            end else begin
              tgt       <= rif.target_gen;
              mask      <= lane_mask(rif.numberOfDetectedLanes);
              drain_cnt <= '0;
              state     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
            rate_q <= tgt;
            sticky <= '0;
            state  <= S_RATE;
          end else if (drain_cnt != '1) begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_RATE: begin
          sticky <= sticky | (rif.PhyStatus & mask);
          // Completion is judged on the registered sticky bits and is tested
          // first, so it beats a timeout expiring in the same cycle.
          if (sticky == mask) begin
            settle_cnt <= '0;
            state      <= S_SETTLE;
          end else if (tmo_hit) begin
            rate_q <= gen_q;
            err_q  <= 1'b1;
            state  <= S_IDLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
            gen_q  <= tgt;
            done_q <= 1'b1;
            state  <= S_DONE;
          end else if (settle_cnt != '1) begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Flush and descrambler-off cover the whole change, through the DONE cycle.
  assign rif.busy               = (state != S_IDLE);
  assign rif.rx_flush           = (state != S_IDLE);
  assign rif.disableDescrambler = (state != S_IDLE);
  assign rif.GEN                = gen_q;
  assign rif.rate_out           = rate_q;
  assign rif.done               = done_q;
  assign rif.err                = err_q;

endmodule

// File: doc/rx_rate_ctrl.md
RX_RATE_CTRL -- requirements
Module: rx_rate_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 4: cycles the RX path is flushed before the rate is switched.
REQ-002 Parameter SETTLE_CYCLES, default 8: cycles held after all-lane PhyStatus before the new rate is released.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: maximum wait for PhyStatus in RATE.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 rate_req  in  1  one-cycle rate-change request pulse.
REQ-007 target_gen  in  3  requested generation; valid values are 1..3.
REQ-008 numberOfDetectedLanes  in  5  active lane count: 1, 2, 4, 8 or 16.
REQ-009 PhyStatus  in  16  per-lane PHY rate-change completion.
REQ-010 GEN  out  3  committed generation that drives the RX datapath.
REQ-011 rate_out  out  3  rate presented to the PHY.
REQ-012 disableDescrambler  out  1  descrambler turn-off.
REQ-013 rx_flush  out  1  discard-data indication to the lane-management and ordered-set/packet stages.
REQ-014 busy, done, err  out  1 each  status outputs; done and err are one-cycle pulses.

Function
REQ-015 The FSM SHALL have the states IDLE, DRAIN, RATE, SETTLE and DONE, one-hot or binary encoded.
REQ-016 On rate_req in IDLE with target_gen in 1..3 and target_gen != GEN, the block SHALL latch target_gen and the lane mask and enter DRAIN on the next cycle.
REQ-017 On rate_req in IDLE with target_gen == GEN, the block SHALL pulse done on the next cycle and remain in IDLE.
REQ-018 On rate_req in IDLE with target_gen of 0 or greater than 3, the block SHALL pulse err on the next cycle and remain in IDLE.
REQ-019 The block SHALL ignore rate_req in any state other than IDLE.
REQ-020 Lane mask: the lowest N bits SHALL be set for N in {1,2,4,8,16}; any other count SHALL be treated as 1 lane.
REQ-021 In DRAIN, rx_flush=1 and disableDescrambler=1; after exactly DRAIN_CYCLES cycles the block SHALL set rate_out to the latched target and enter RATE.
REQ-022 In RATE, a sticky per-lane register SHALL be cleared on entry and SHALL accumulate PhyStatus AND mask.
REQ-023 When the sticky register equals the mask, the block SHALL enter SETTLE.
REQ-024 In SETTLE, rx_flush stays 1; after exactly SETTLE_CYCLES cycles the block SHALL enter DONE.
REQ-025 In DONE (one cycle), GEN SHALL take the latched target and done SHALL pulse; rx_flush and disableDescrambler SHALL drop on the next cycle, when the block returns to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 Latency from the rate_req cycle to the done pulse SHALL be 1 + DRAIN_CYCLES + (PhyStatus wait) + SETTLE_CYCLES + 1 cycles.
REQ-028 Counters SHALL be sized by $clog2 of their parameter plus 1, and SHALL saturate, never wrap.

Reset
REQ-029 While reset is high: state=IDLE, GEN=1, rate_out=1, disableDescrambler=0, rx_flush=0, busy=0, done=0, err=0, and all counters and sticky bits cleared.
REQ-030 A reset asserted mid-operation SHALL abort the change with no done or err pulse, and GEN SHALL return to 1.

Configuration
REQ-031 Macro RX_RATE_CTRL_TIMEOUT_EN defined: in RATE, after TIMEOUT_CYCLES cycles without completion, the block SHALL restore rate_out to GEN, pulse err, drop rx_flush and disableDescrambler, and return to IDLE with GEN unchanged.
REQ-032 If completion and timeout occur in the same cycle, completion SHALL win.
REQ-033 Macro RX_RATE_CTRL_TIMEOUT_EN undefined: no timeout counter SHALL be built, and RATE SHALL wait indefinitely.

Verification
REQ-034 Reset, then rate_req with target_gen=3, 2 lanes, PhyStatus=16'h0003 on the 3rd RATE cycle -> rate_out=3 after 5 cycles, done at cycle 1+4+3+8+1=17, GEN=3.
REQ-035 Staggered PhyStatus (lane0, then lane1 three cycles later) with 2 lanes -> SETTLE entered only after lane1; PhyStatus on lanes 2..15 has no effect.
REQ-036 rate_req with target_gen=GEN -> done at +1, busy stays 0; target_gen=0 or 5 -> err at +1; a rate_req during DRAIN is ignored.
REQ-037 With TIMEOUT_EN defined and PhyStatus held at 0 -> err at TIMEOUT_CYCLES into RATE, rate_out reverts to 1, GEN=1; without the macro, busy stays 1 and no err pulse occurs.
REQ-038 reset asserted in SETTLE -> next cycle: IDLE, GEN=1, rx_flush=0, no done pulse; a following rate_req completes normally.
